// File: rtl/axi_burst_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi_burst_sram_slave
// Description : AXI3 slave terminating FIXED/INCR/WRAP bursts on an internal
//               synchronous memory, with independent read and write engines.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_sram_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 1024,
  parameter int LEN_W  = 4
) (
  input  logic                a_clk,
  input  logic                a_resetn,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [LEN_W-1:0]    aw_len,
  input  logic [2:0]          aw_size,
  input  logic [1:0]          aw_burst,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_last,
  input  logic                w_valid,
  output logic                w_ready,
  output logic [ID_W-1:0]     b_id,
  output logic [1:0]          b_resp,
  output logic                b_valid,
  input  logic                b_ready,
  input  logic [ID_W-1:0]     ar_id,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic [LEN_W-1:0]    ar_len,
  input  logic [2:0]          ar_size,
  input  logic [1:0]          ar_burst,
  input  logic                ar_valid,
  output logic                ar_ready,
  output logic [ID_W-1:0]     r_id,
  output logic [DATA_W-1:0]   r_data,
  output logic [1:0]          r_resp,
  output logic                r_last,
  output logic                r_valid,
  input  logic                r_ready
);

  localparam int c_BYTES = DATA_W / 8;
  localparam int c_OFF_W = $clog2(c_BYTES);
  localparam int c_IDX_W = $clog2(DEPTH);

  localparam logic [1:0] c_BURST_INCR = 2'b01;
  localparam logic [1:0] c_BURST_WRAP = 2'b10;
  localparam logic [1:0] c_BURST_RSVD = 2'b11;
  localparam logic [1:0] c_RESP_OKAY  = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  localparam logic [1:0] c_W_IDLE = 2'd0;
  localparam logic [1:0] c_W_DATA = 2'd1;
  localparam logic [1:0] c_W_RESP = 2'd2;
  localparam logic [0:0] c_R_IDLE = 1'b0;
  localparam logic [0:0] c_R_DATA = 1'b1;

  // Errors that condemn every beat of a burst, known at address time
  function automatic logic burst_err(input logic [LEN_W-1:0] len,
                                     input logic [2:0]       size,
                                     input logic [1:0]       burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                  (len == LEN_W'(7)) || (len == LEN_W'(15));
    return (int'(size) > c_OFF_W) || (burst == c_BURST_RSVD) ||
           ((burst == c_BURST_WRAP) && !wrap_len_ok);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [LEN_W-1:0]  len,
                                                  input logic [2:0]        size,
                                                  input logic [1:0]        burst);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] mask;
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      c_BURST_INCR: return addr + step;
      c_BURST_WRAP: return (addr & ~mask) | ((addr + step) & mask);
      default:      return addr;
    endcase
  endfunction

  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
    return (addr >> c_OFF_W) >= ADDR_W'(DEPTH);
  endfunction

  function automatic logic [c_IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[c_OFF_W +: c_IDX_W];
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Write engine
  // --------------------------------------------------------------------------
  logic [1:0]        r_wstate;
  logic [ID_W-1:0]   r_wid;
  logic [ADDR_W-1:0] r_waddr;
  logic [LEN_W-1:0]  r_wlen;
  logic [LEN_W-1:0]  r_wcnt;
  logic [2:0]        r_wsize;
  logic [1:0]        r_wburst;
  logic              r_wburst_err;
  logic              r_werr;

  logic w_w_hs;
  logic w_wbeat_err;
  logic w_wlast_beat;
  logic w_mem_we;

  assign aw_ready     = (r_wstate == c_W_IDLE);
  assign w_ready      = (r_wstate == c_W_DATA);
  assign b_valid      = (r_wstate == c_W_RESP);
  assign b_id         = r_wid;
  assign b_resp       = r_werr ? c_RESP_SLVERR : c_RESP_OKAY;

  assign w_w_hs       = w_valid && w_ready;
  assign w_wbeat_err  = r_wburst_err || out_of_range(r_waddr);
  assign w_wlast_beat = (r_wcnt == r_wlen);
  assign w_mem_we     = w_w_hs && !w_wbeat_err;

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      r_wstate     <= c_W_IDLE;
      r_wid        <= '0;
      r_waddr      <= '0;
      r_wlen       <= '0;
      r_wcnt       <= '0;
      r_wsize      <= '0;
      r_wburst     <= '0;
      r_wburst_err <= 1'b0;
      r_werr       <= 1'b0;
    end else begin
      case (r_wstate)
        c_W_IDLE: begin
          if (aw_valid) begin
            r_wid        <= aw_id;
            r_waddr      <= aw_addr;
            r_wlen       <= aw_len;
            r_wsize      <= aw_size;
            r_wburst     <= aw_burst;
            r_wburst_err <= burst_err(aw_len, aw_size, aw_burst);
            r_werr       <= burst_err(aw_len, aw_size, aw_burst);
            r_wcnt       <= '0;
            r_wstate     <= c_W_DATA;
          end
        end
        c_W_DATA: begin
          if (w_valid) begin
            // A misplaced w_last is flagged, but the beat count still ends the burst
            r_werr  <= r_werr | w_wbeat_err | (w_last != w_wlast_beat);
            r_waddr <= next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
            r_wcnt  <= r_wcnt + LEN_W'(1);
            if (w_wlast_beat) begin
              r_wstate <= c_W_RESP;
            end
          end
        end
        c_W_RESP: begin
          if (b_ready) begin
            r_wstate <= c_W_IDLE;
          end
        end
        default: r_wstate <= c_W_IDLE;
      endcase
    end
  end

  always_ff @(posedge a_clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < c_BYTES; b++) begin
        if (w_strb[b]) begin
          r_mem[word_idx(r_waddr)][b*8 +: 8] <= w_data[b*8 +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read engine
  // --------------------------------------------------------------------------
  logic [0:0]        r_rstate;
  logic [ID_W-1:0]   r_rid;
  logic [ADDR_W-1:0] r_raddr;
  logic [LEN_W-1:0]  r_rlen;
  logic [LEN_W-1:0]  r_rcnt;
  logic [2:0]        r_rsize;
  logic [1:0]        r_rburst;
  logic              r_rburst_err;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              r_rlast;

  logic              w_r_hs;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_fetch_err;
  logic [DATA_W-1:0] w_fetch_data;

  assign ar_ready = (r_rstate == c_R_IDLE);
  assign r_valid  = (r_rstate == c_R_DATA);
  assign r_id     = r_rid;
  assign r_data   = r_rdata;
  assign r_resp   = r_rresp;
  assign r_last   = r_rlast;
  assign w_r_hs   = r_valid && r_ready;

  // In IDLE the first beat is fetched straight from the AR channel; the
  // registered read sees pre-write memory contents on a same-word collision.
  assign w_fetch_addr = (r_rstate == c_R_IDLE) ? ar_addr : r_raddr;
  assign w_fetch_err  = ((r_rstate == c_R_IDLE) ? burst_err(ar_len, ar_size, ar_burst)
                                                : r_rburst_err)
                        || out_of_range(w_fetch_addr);
  assign w_fetch_data = w_fetch_err ? '0 : r_mem[word_idx(w_fetch_addr)];

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      r_rstate     <= c_R_IDLE;
      r_rid        <= '0;
      r_raddr      <= '0;
      r_rlen       <= '0;
      r_rcnt       <= '0;
      r_rsize      <= '0;
      r_rburst     <= '0;
      r_rburst_err <= 1'b0;
      r_rdata      <= '0;
      r_rresp      <= '0;
      r_rlast      <= 1'b0;
    end else begin
      case (r_rstate)
        c_R_IDLE: begin
          if (ar_valid) begin
            r_rid        <= ar_id;
            r_rlen       <= ar_len;
            r_rsize      <= ar_size;
            r_rburst     <= ar_burst;
            r_rburst_err <= burst_err(ar_len, ar_size, ar_burst);
            r_raddr      <= next_addr(ar_addr, ar_len, ar_size, ar_burst);
            r_rcnt       <= '0;
            r_rdata      <= w_fetch_data;
            r_rresp      <= w_fetch_err ? c_RESP_SLVERR : c_RESP_OKAY;
            r_rlast      <= (ar_len == '0);
            r_rstate     <= c_R_DATA;
          end
        end
        c_R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rlast  <= 1'b0;
              r_rstate <= c_R_IDLE;
            end else begin
              r_rcnt  <= r_rcnt + LEN_W'(1);
              r_rdata <= w_fetch_data;
              r_rresp <= w_fetch_err ? c_RESP_SLVERR : c_RESP_OKAY;
              r_rlast <= ((r_rcnt + LEN_W'(1)) == r_rlen);
              r_raddr <= next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
            end
          end
        end
        default: r_rstate <= c_R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_sram_slave
// Description : Scoreboard bench for axi_burst_sram_slave (DATA_W=32, DEPTH=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_sram_slave;

  logic        a_clk = 1'b0;
  logic        a_resetn = 1'b0;
  logic [3:0]  aw_id = '0, ar_id = '0;
  logic [31:0] aw_addr = '0, ar_addr = '0;
  logic [3:0]  aw_len = '0, ar_len = '0;
  logic [2:0]  aw_size = '0, ar_size = '0;
  logic [1:0]  aw_burst = '0, ar_burst = '0;
  logic        aw_valid = 1'b0, ar_valid = 1'b0;
  logic        aw_ready, ar_ready;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        w_last = 1'b0, w_valid = 1'b0, w_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready = 1'b0;
  logic [3:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last, r_valid, r_ready = 1'b0;

  axi_burst_sram_slave #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .DEPTH(64), .LEN_W(4)) dut (
    .a_clk(a_clk), .a_resetn(a_resetn),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 a_clk = ~a_clk;

  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } r_exp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;

  r_exp_t      rq[$];
  b_exp_t      bq[$];
  logic [31:0] wbuf[16];
  logic [31:0] rbuf_d[16];
  logic [1:0]  rbuf_r[16];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          bp = 0;   // 0: ready held high, 1: random, 2: ready held low

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge a_clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge a_clk); #1;
    r_ready = (bp == 0) ? 1'b1 : (bp == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    b_ready = (bp == 0) ? 1'b1 : (bp == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Monitor: pops expectations on every handshake, checks stall stability
  logic        r_stalled = 1'b0;
  logic [35:0] r_held = '0;
  always @(negedge a_clk) begin
    if (!a_resetn) begin
      r_stalled = 1'b0;
    end else begin
      if (r_stalled) chk("r_hold_stable", {r_valid, r_data, r_resp, r_last}, r_held);
      if (r_valid && r_ready) begin
        if (rq.size() == 0) chk("r_unexpected_beat", r_valid, 1'b0);
        else begin
          r_exp_t e;
          e = rq.pop_front();
          chk("r_data", r_data, e.data);
          chk("r_resp", r_resp, e.resp);
          chk("r_last", r_last, e.last);
          chk("r_id", r_id, e.id);
          if (r_last) last_cyc = cyc;
        end
      end
      r_stalled = r_valid && !r_ready;
      r_held    = {r_valid, r_data, r_resp, r_last};
      if (b_valid && b_ready) begin
        if (bq.size() == 0) chk("b_unexpected", b_valid, 1'b0);
        else begin
          b_exp_t e;
          e = bq.pop_front();
          chk("b_id", b_id, e.id);
          chk("b_resp", b_resp, e.resp);
        end
      end
    end
  end

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [1:0] burst, input logic [3:0] strb,
                    input logic [1:0] exp_resp, input bit all_last);
    int n;
    bq.push_back('{id: id, resp: exp_resp});
    @(posedge a_clk); #1;
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd2; aw_burst = burst; aw_valid = 1'b1;
    n = 0;
    do begin @(negedge a_clk); n++; end while (!aw_ready && n < 100);
    chk("aw_handshake", aw_ready, 1'b1);
    @(posedge a_clk); #1;
    aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_data = wbuf[i]; w_strb = strb; w_last = all_last || (i == int'(len)); w_valid = 1'b1;
      n = 0;
      do begin @(negedge a_clk); n++; end while (!w_ready && n < 100);
      chk("w_handshake", w_ready, 1'b1);
      @(posedge a_clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    n = 0;
    while (bq.size() != 0 && n < 200) begin @(negedge a_clk); n++; end
    chk("b_drained", bq.size(), 0);
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [1:0] burst, input bit rate_chk);
    int n;
    int ar_cyc;
    for (int i = 0; i <= int'(len); i++)
      rq.push_back('{data: rbuf_d[i], resp: rbuf_r[i], last: (i == int'(len)), id: id});
    @(posedge a_clk); #1;
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = 3'd2; ar_burst = burst; ar_valid = 1'b1;
    n = 0;
    do begin @(negedge a_clk); n++; end while (!ar_ready && n < 100);
    chk("ar_handshake", ar_ready, 1'b1);
    ar_cyc = cyc;
    @(posedge a_clk); #1;
    ar_valid = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 300) begin @(negedge a_clk); n++; end
    chk("r_drained", rq.size(), 0);
    if (rate_chk) chk("r_full_rate", last_cyc - ar_cyc, int'(len) + 1);
  endtask

  task automatic set_rd(input int i, input logic [31:0] d, input logic [1:0] r);
    rbuf_d[i] = d; rbuf_r[i] = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge a_clk);
    #1 a_resetn = 1'b1;
    @(negedge a_clk);
    chk("rst_aw_ready", aw_ready, 1'b1);
    chk("rst_ar_ready", ar_ready, 1'b1);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_r_outs", {r_data, r_resp, r_last, r_id, b_resp, b_id}, 64'd0);

    // INCR 4-beat write then read back at 0x10 (words 4..7)
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
    wr(4'd3, 32'h10, 4'd3, 2'b01, 4'hF, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) set_rd(i, 32'hA0 + i, 2'b00);
    rd(4'd5, 32'h10, 4'd3, 2'b01, 1'b1);

    // WRAP len=3 from 0x18 visits words 6,7,4,5
    set_rd(0, 32'hA2, 2'b00); set_rd(1, 32'hA3, 2'b00);
    set_rd(2, 32'hA0, 2'b00); set_rd(3, 32'hA1, 2'b00);
    rd(4'd6, 32'h18, 4'd3, 2'b10, 1'b1);

    // WRAP len=2 is illegal: every beat errors with zero data
    for (int i = 0; i < 3; i++) set_rd(i, 32'h0, 2'b10);
    rd(4'd7, 32'h18, 4'd2, 2'b10, 1'b1);

    // Byte strobes: lanes 0 and 2 only
    wbuf[0] = 32'h11111111;
    wr(4'd1, 32'h40, 4'd0, 2'b01, 4'hF, 2'b00, 1'b0);
    wbuf[0] = 32'hDEADBEEF;
    wr(4'd2, 32'h40, 4'd0, 2'b01, 4'h5, 2'b00, 1'b0);
    set_rd(0, 32'h11AD11EF, 2'b00);
    rd(4'd2, 32'h40, 4'd0, 2'b01, 1'b1);

    // FIXED write of 3 beats leaves only the last value
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
    wr(4'd4, 32'h44, 4'd2, 2'b00, 4'hF, 2'b00, 1'b0);
    set_rd(0, 32'h3, 2'b00);
    rd(4'd4, 32'h44, 4'd0, 2'b01, 1'b1);

    // End of memory: second beat at word 64 errors, word 0 is not aliased
    wbuf[0] = 32'h77;
    wr(4'd8, 32'h0, 4'd0, 2'b01, 4'hF, 2'b00, 1'b0);
    wbuf[0] = 32'h55; wbuf[1] = 32'h66;
    wr(4'd9, 32'hFC, 4'd1, 2'b01, 4'hF, 2'b10, 1'b0);
    set_rd(0, 32'h55, 2'b00); set_rd(1, 32'h0, 2'b10);
    rd(4'd9, 32'hFC, 4'd1, 2'b01, 1'b1);
    set_rd(0, 32'h77, 2'b00);
    rd(4'd10, 32'h0, 4'd0, 2'b01, 1'b1);

    // Early w_last flags SLVERR
    wbuf[0] = 32'hAB; wbuf[1] = 32'hCD;
    wr(4'd11, 32'h48, 4'd1, 2'b01, 4'hF, 2'b10, 1'b1);

    // Overlapping write and read under random back-pressure
    bp = 1;
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0DE0000 + i;
    for (int i = 0; i < 4; i++) set_rd(i, 32'hA0 + i, 2'b00);
    fork
      wr(4'd12, 32'h80, 4'd7, 2'b01, 4'hF, 2'b00, 1'b0);
      rd(4'd13, 32'h10, 4'd3, 2'b01, 1'b0);
    join
    for (int i = 0; i < 8; i++) set_rd(i, 32'hC0DE0000 + i, 2'b00);
    rd(4'd14, 32'h80, 4'd7, 2'b01, 1'b0);
    bp = 0;
    rd(4'd15, 32'h80, 4'd7, 2'b01, 1'b1);

    // Reset in the middle of a write and a stalled read
    bp = 2;
    @(posedge a_clk); #1;
    aw_id = 4'd1; aw_addr = 32'hC0; aw_len = 4'd7; aw_size = 3'd2; aw_burst = 2'b01; aw_valid = 1'b1;
    ar_id = 4'd2; ar_addr = 32'h80; ar_len = 4'd7; ar_size = 3'd2; ar_burst = 2'b01; ar_valid = 1'b1;
    @(posedge a_clk); #1;
    aw_valid = 1'b0; ar_valid = 1'b0;
    w_data = 32'h1234; w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
    @(posedge a_clk); #1;
    w_data = 32'h5678;
    @(posedge a_clk); #1;
    w_valid = 1'b0;
    @(negedge a_clk);
    chk("mid_r_valid", r_valid, 1'b1);
    chk("mid_w_ready", w_ready, 1'b1);
    @(posedge a_clk); #1;
    a_resetn = 1'b0;
    #1;
    chk("mrst_aw_ready", aw_ready, 1'b1);
    chk("mrst_ar_ready", ar_ready, 1'b1);
    chk("mrst_w_ready", w_ready, 1'b0);
    chk("mrst_r_valid", r_valid, 1'b0);
    chk("mrst_b_valid", b_valid, 1'b0);
    chk("mrst_r_last", r_last, 1'b0);
    repeat (2) @(posedge a_clk);
    #1 a_resetn = 1'b1; bp = 0;

    wbuf[0] = 32'h900D0001; wbuf[1] = 32'h900D0002;
    wr(4'd5, 32'hC0, 4'd1, 2'b01, 4'hF, 2'b00, 1'b0);
    set_rd(0, 32'h900D0001, 2'b00); set_rd(1, 32'h900D0002, 2'b00);
    rd(4'd6, 32'hC0, 4'd1, 2'b01, 1'b1);

    repeat (3) @(negedge a_clk);
    chk("end_rq_empty", rq.size(), 0);
    chk("end_bq_empty", bq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_burst_sram_slave.md
Name: axi_burst_sram_slave

Overview:
- Parametrised AXI3 slave that terminates AXI directly on an internal synchronous memory array, with no AHB hop.
- Generalises the fixed 32-bit AXI front end to configurable data, address and ID widths, and configurable depth.
- Adds full FIXED/INCR/WRAP burst addressing, narrow transfers, and SLVERR signalling.
- Independent read and write engines; intended as the next-generation memory endpoint behind the AXI interconnect.

Parameters:
DATA_W, 32, data bus width in bits; one of 32/64/128
ADDR_W, 32, address width
ID_W, 4, transaction ID width
DEPTH, 1024, memory depth in DATA_W words
LEN_W, 4, burst length field width (AXI3)

Ports:
a_clk  in  1  clock
a_resetn  in  1  asynchronous active-low reset
aw_id  in  ID_W  write ID
aw_addr  in  ADDR_W  write start byte address
aw_len  in  LEN_W  beats minus one
aw_size  in  3  log2 bytes per beat
aw_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
aw_valid  in  1  write address valid
aw_ready  out  1  write address ready
w_data  in  DATA_W  write data
w_strb  in  DATA_W/8  byte enables
w_last  in  1  final write beat
w_valid  in  1  write data valid
w_ready  out  1  write data ready
b_id  out  ID_W  response ID (= latched aw_id)
b_resp  out  2  00 OKAY, 10 SLVERR
b_valid  out  1  response valid
b_ready  in  1  response ready
ar_id  in  ID_W  read ID
ar_addr  in  ADDR_W  read start byte address
ar_len  in  LEN_W  beats minus one
ar_size  in  3  log2 bytes per beat
ar_burst  in  2  burst type
ar_valid  in  1  read address valid
ar_ready  out  1  read address ready
r_id  out  ID_W  read ID (= latched ar_id)
r_data  out  DATA_W  read data
r_resp  out  2  per-beat response
r_last  out  1  final read beat
r_valid  out  1  read data valid
r_ready  in  1  read data ready

Behaviour:
- Reset: both FSMs go to IDLE; aw_ready=ar_ready=1 (decoded from IDLE); all other outputs 0. Memory contents are not reset. Reset mid-burst abandons the burst with no B/R response.
- Word index = addr >> log2(DATA_W/8). Beat step = 1<<size bytes.
- FIXED: address constant. INCR: address += step. WRAP: wraps within an aligned block of (len+1)*step bytes.
- Burst-level SLVERR conditions: size > log2(DATA_W/8); burst=11; WRAP with len not in {1,3,7,15}. Beat-level SLVERR: word index >= DEPTH.
- An erroring write beat does not modify memory. An erroring read beat returns r_data=0.
- Write FSM:
  - W_IDLE (aw_ready=1): on aw handshake, latch id/addr/len/size/burst and go to W_DATA.
  - W_DATA (w_ready=1): each w handshake writes the bytes enabled by w_strb, then advances the address and beat count.
  - After beat len+1, go to W_RESP. w_last on the wrong beat, or missing on the final beat, sets SLVERR; the count still governs burst end.
  - W_RESP (b_valid=1): b_resp is the OR of all errors in the burst; on b_ready go to W_IDLE.
- Read FSM:
  - R_IDLE (ar_ready=1): on ar handshake, latch fields and go to R_DATA.
  - R_DATA: r_valid rises 1 cycle after the AR handshake. Thereafter one beat per cycle while r_ready=1 (full throughput).
  - r_data/r_resp/r_last hold stable while r_valid && !r_ready.
  - r_last=1 on beat len+1; its handshake returns the FSM to R_IDLE.
- One outstanding transaction per channel; reads and writes run concurrently.
- Same-cycle read and write to the same word: the read returns the old data.
- aw_ready and ar_ready next assert the cycle after the FSM returns to IDLE. No combinational path from valid to ready.

Test Plan:
- INCR write of 4 beats (DATA_W=32) at 0x10, data 0xA0..0xA3, strb=F, then INCR read of 4 beats at 0x10 -> r_data A0,A1,A2,A3; r_last only on beat 4; b_resp=00, b_id=aw_id.
- WRAP read, len=3, size=2, addr 0x18 -> addresses 0x18,0x1C,0x10,0x14. WRAP with len=2 -> all beats SLVERR.
- Write 0xDEADBEEF with strb=0101 over 0x11111111 -> read back 0x11AD11EF. FIXED write of 3 beats -> only the last value remains.
- Write at word DEPTH-1 with INCR len=1 -> beat 2 SLVERR, memory unchanged past the end, b_resp=10. Same pattern as a read -> beat 2 r_resp=10, r_data=0.
- Random r_ready/b_ready back-pressure during overlapping read and write bursts -> r_data stable while stalled, no lost or duplicated beats, full rate when ready=1.
- Assert a_resetn low mid-write and mid-read -> outputs at reset values immediately; next transaction completes normally.
